id_issue_queue: RTL

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/id_issue_queue_pkg.sv | 22 ++
 rtl/id_issue_queue_if.sv | 29 ++
 rtl/id_issue_queue.sv | 60 ++++++
 3 files changed

// File: rtl/id_issue_queue_pkg.sv
// id_issue_queue_pkg: shared types and constants for the decode-to-issue queue.
package id_issue_queue_pkg;
    localparam int ID_ISSUE_QUEUE_DEPTH = 4;
    typedef enum logic [3:0] {
        FU_NONE,
        FU_ALU,
        FU_CTRL_FLOW,
        FU_LOAD,
        FU_STORE,
        FU_MULT
    } fu_t;
    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        valid;
    } scoreboard_entry_t;
endpackage

// File: rtl/id_issue_queue_if.sv
// id_issue_queue_if: decode-side and issue-side handshake bundle of the issue queue.
interface id_issue_queue_if #(parameter int DEPTH = 4) ();
    import id_issue_queue_pkg::*;
    logic                         flush_i;
    scoreboard_entry_t            decoded_instr_i;
    logic                         decoded_instr_valid_i;
    logic                         is_ctrl_flow_i;
    logic                         decoded_instr_ack_o;
    scoreboard_entry_t            issue_instr_o;
    logic                         issue_instr_valid_o;
    logic                         is_ctrl_flow_o;
    logic                         issue_ack_i;
    logic                         resolve_branch_i;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         full_o;
    logic                         empty_o;
    modport slave (
        input  flush_i, decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i,
               issue_ack_i, resolve_branch_i,
        output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, is_ctrl_flow_o,
               count_o, full_o, empty_o
    );
    modport master (
        output flush_i, decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i,
               issue_ack_i, resolve_branch_i,
        input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, is_ctrl_flow_o,
               count_o, full_o, empty_o
    );
endinterface

// File: rtl/id_issue_queue.sv
// id_issue_queue: FIFO of decoded instructions between decode and issue, holding
// back a branch head while an earlier issued branch is still unresolved.
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int DEPTH = ID_ISSUE_QUEUE_DEPTH
) (
    input logic          clk_i,
    input logic          rst_i,
    id_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    scoreboard_entry_t mem_q [DEPTH];
    logic [DEPTH-1:0]  ctrl_q;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bp_q, bp_d;
    logic              push, pop, head_ctrl;

    assign head_ctrl               = ctrl_q[rd_ptr_q];
    assign bus.full_o              = cnt_q == CW'(DEPTH);
    assign bus.empty_o             = cnt_q == '0;
    assign bus.count_o             = cnt_q;
    assign bus.decoded_instr_ack_o = !bus.full_o && !bus.flush_i;
    assign bus.issue_instr_valid_o = !bus.empty_o && !(bp_q && head_ctrl);
    assign bus.issue_instr_o       = mem_q[rd_ptr_q];
    assign bus.is_ctrl_flow_o      = !bus.empty_o && head_ctrl;
    assign push = bus.decoded_instr_valid_i && bus.decoded_instr_ack_o;
    assign pop  = bus.issue_instr_valid_o && bus.issue_ack_i && !bus.flush_i;

    // Popping a branch arms the gate even if the previous one resolves this cycle.
    always_comb begin
        rd_ptr_d = bus.flush_i ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = bus.flush_i ? '0 : wr_ptr_q + PW'(push);
        cnt_d    = bus.flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        bp_d     = bus.flush_i ? 1'b0 : (pop && head_ctrl) ? 1'b1 : bus.resolve_branch_i ? 1'b0 : bp_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            ctrl_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            bp_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]  <= bus.decoded_instr_i;
                ctrl_q[wr_ptr_q] <= bus.is_ctrl_flow_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            bp_q     <= bp_d;
        end
    end
endmodule
